// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and the flag bundle.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
  } alu_flags_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// lo_o holds the low product / quotient, hi_o the high product / remainder.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CNTW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   opndQ;
  logic [CNTW-1:0]    cntQ;
  logic               divQ, runQ, doneQ;

  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divTry;
  logic [WIDTH-1:0]   divDiff;

  // Both algorithms keep the live operand in acc's low half and the partial
  // result (product high / remainder) in its high half.
  always_comb begin
    mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opndQ} : '0);
    divTry  = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
    divDiff = divTry[WIDTH-1:0] - opndQ;
    accD    = accQ;
    if (divQ) begin
      if (divTry >= {1'b0, opndQ}) begin
        accD = {divDiff, accQ[WIDTH-2:0], 1'b1};
      end else begin
        accD = {divTry[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0};
      end
    end else begin
      accD = {mulSum, accQ[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accQ  <= '0;
      opndQ <= '0;
      cntQ  <= '0;
      divQ  <= 1'b0;
      runQ  <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (start_i) begin
        accQ  <= {{WIDTH{1'b0}}, a_i};
        opndQ <= b_i;
        cntQ  <= '0;
        divQ  <= div_i;
        runQ  <= 1'b1;
      end else if (runQ) begin
        accQ <= accD;
        cntQ <= cntQ + 1'b1;
        if (cntQ == CNTW'(WIDTH - 1)) begin
          runQ  <= 1'b0;
          doneQ <= 1'b1;
        end
      end
    end
  end

  assign done_o = doneQ;
  assign lo_o   = accQ[WIDTH-1:0];
  assign hi_o   = accQ[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc_pipe.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops complete in one
// cycle, multiply/divide run through alu_muldiv_iter and take WIDTH+2 cycles.
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       stateQ, stateD;
  logic [WIDTH-1:0] resultQ, resultD;
  alu_flags_t       flagsQ, flagsD;
  logic             outValidQ, outValidD;
  logic [3:0]       opQ;

  logic [3:0]       opCode;
  logic             accept, iterStart, iterDone;
  logic [WIDTH-1:0] iterLo, iterHi, iterRes;
  logic             isSub, isAddSub, cout, addOvf;
  logic [WIDTH-1:0] addB, sum, aluRes;
  logic [SHW-1:0]   shamt;
  alu_flags_t       aluFlags, iterFlags;

  assign opCode    = alu_control[3:0];
  assign shamt     = b[SHW-1:0];
  assign in_ready  = (stateQ == ST_IDLE) && (!outValidQ || out_ready) && !rst;
  assign accept    = in_valid && in_ready;
  assign iterStart = accept && is_iter_op(opCode);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start_i(iterStart),
    .div_i  (is_div_op(opCode)),
    .a_i    (a),
    .b_i    (b),
    .done_o (iterDone),
    .lo_o   (iterLo),
    .hi_o   (iterHi)
  );

  // Sub reuses the adder: A + ~B + 1, so carry out means "no borrow".
  assign isSub    = (opCode == ALU_SUB);
  assign isAddSub = (opCode == ALU_ADD) || isSub;
  assign addB     = isSub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, addB} + {{WIDTH{1'b0}}, isSub};
  assign addOvf   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ isSub) & (a[WIDTH-1] ^ sum[WIDTH-1]);

  always_comb begin
    aluRes = '0;
    case (opCode)
      ALU_ADD, ALU_SUB: aluRes = sum;
      ALU_AND:          aluRes = a & b;
      ALU_OR:           aluRes = a | b;
      ALU_XOR:          aluRes = a ^ b;
      ALU_SLT:          aluRes = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:         aluRes = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:          aluRes = a << shamt;
      ALU_SRL:          aluRes = a >> shamt;
      ALU_SRA:          aluRes = $signed(a) >>> shamt;
      default:          aluRes = '0;
    endcase
    aluFlags.zero     = (aluRes == '0);
    aluFlags.negative = aluRes[WIDTH-1];
    aluFlags.overflow = isAddSub & addOvf;
    aluFlags.carry    = isAddSub & cout;
  end

  always_comb begin
    iterRes = ((opQ == ALU_MUL) || (opQ == ALU_DIVU)) ? iterLo : iterHi;
    iterFlags.zero     = (iterRes == '0);
    iterFlags.negative = iterRes[WIDTH-1];
    iterFlags.overflow = 1'b0;
    iterFlags.carry    = 1'b0;
  end

  // DONE waits for a free output slot so a stalled result is never overwritten.
  always_comb begin
    stateD    = stateQ;
    resultD   = resultQ;
    flagsD    = flagsQ;
    outValidD = outValidQ;
    if (outValidQ && out_ready) begin
      outValidD = 1'b0;
    end
    case (stateQ)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter_op(opCode)) begin
            stateD = is_div_op(opCode) ? ST_DIV : ST_MUL;
          end else begin
            resultD   = aluRes;
            flagsD    = aluFlags;
            outValidD = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iterDone) begin
          stateD = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!outValidQ || out_ready) begin
          resultD   = iterRes;
          flagsD    = iterFlags;
          outValidD = 1'b1;
          stateD    = ST_IDLE;
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= ST_IDLE;
      resultQ   <= '0;
      flagsQ    <= '0;
      outValidQ <= 1'b0;
      opQ       <= '0;
    end else begin
      stateQ    <= stateD;
      resultQ   <= resultD;
      flagsQ    <= flagsD;
      outValidQ <= outValidD;
      if (iterStart) begin
        opQ <= opCode;
      end
    end
  end

  assign out_valid = outValidQ;
  assign result    = resultQ;
  assign zero      = flagsQ.zero;
  assign negative  = flagsQ.negative;
  assign overflow  = flagsQ.overflow;
  assign carry     = flagsQ.carry;
  assign busy      = (stateQ != ST_IDLE);

endmodule

// File: doc/alu_mc_pipe.md
Name: alu_mc_pipe

Overview:
- Parametrised multi-cycle ALU, next generation of the single-cycle 32-bit ALU. Adds configurable width, xor/sltu/shift ops and iterative multiply/divide.
- Operands and results move through a registered valid/ready handshake. Registered Zero/Negative/Overflow/Carry flags travel with each result.
- Sits between the decode/operand-fetch stage and writeback of the multi-cycle core.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of two)
- CW, 4, ALU control code width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an op this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[$clog2(WIDTH)-1:0])
- alu_control  in  CW  operation code
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- overflow  out  1  signed overflow (add/sub only, else 0)
- carry  out  1  carry out (add/sub only, else 0; sub carry = no-borrow)
- busy  out  1  iterative op in progress

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, in_ready 0 during reset and 1 the first cycle after.
- Op codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 mul (low WIDTH bits), 1011 mulhu (high WIDTH bits, unsigned), 1100 divu, 1101 remu. Codes 1110/1111 give result 0 with normal flag rules.
- slt/sltu results are zero-extended to WIDTH (value 0 or 1).
- Add/sub: single adder with A + (B or ~B) + sub.
  - carry = adder cout.
  - overflow = ~(A[msb]^B[msb]^sub) & (A[msb]^sum[msb]).
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A result is held stable with out_valid=1 until out_valid && out_ready.
  - Acceptance in the same cycle as the output being taken is allowed (full throughput for single-cycle ops).
- FSM states:
  - IDLE: accept. Single-cycle op -> result/flags registered, out_valid=1 next cycle (latency 1), stay IDLE. Mul/div op -> latch operands, counter=0, busy=1, go MUL or DIV.
  - MUL: shift-add, one bit per cycle, 2*WIDTH product register. After WIDTH iterations -> DONE.
  - DIV: restoring, one quotient bit per cycle. After WIDTH iterations -> DONE.
  - DONE: load result/flags, out_valid=1, busy=0, go IDLE.
- Mul/div latency: WIDTH+2 cycles from accept edge to out_valid (34 at WIDTH=32). in_ready stays 0 throughout.
- Divide by zero: divu -> all ones; remu -> a. No trap, same latency.
- Output stall: if out_valid && !out_ready when the iteration finishes, DONE holds until the slot frees. No result is overwritten.
- rst mid-operation aborts the iteration, clears out_valid/busy, and discards the pending result.
- in_valid while in_ready=0 is ignored; the producer must hold its inputs.

Decomposition:
- Shared package alu_pkg: op-code localparams (ALU_ADD..ALU_REMU), state encoding, flag bundle typedef.
- One sub-module alu_muldiv_iter: the iterative multiply/divide datapath with start/done, counter and product/remainder registers. The top holds the handshake, FSM, single-cycle ops and flag logic.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> all outputs 0, in_ready=0; the cycle after release in_ready=1.
- Add overflow (WIDTH=32): a=0x7FFFFFFF, b=1, add -> next cycle result=0x80000000, negative=1, overflow=1, carry=0, zero=0.
- Sub equal: a=5, b=5, sub -> result=0, zero=1, carry=1, overflow=0. slt a=0xFFFFFFFF, b=1 -> 1; sltu same operands -> 0. sra 0x80000000 by 4 -> 0xF8000000.
- Back-to-back: 4 add ops with out_ready=1 every cycle -> 4 results on 4 consecutive cycles. With out_ready=0 for 3 cycles, result held stable and in_ready=0 until taken.
- Multiply/divide: mul 0xFFFF x 0x10001 -> 0xFFFFFFFF, mulhu 0xFFFFFFFF x 2 -> 1, divu 100/7 -> 14, remu 100/7 -> 2, each at out_valid exactly 34 cycles after accept with busy=1 meanwhile. divu 9/0 -> 0xFFFFFFFF, remu 9/0 -> 9.
- Abort: assert rst at iteration 10 of a divu -> out_valid never rises for it. A following add 2+3 yields 5 with latency 1.
